// File: rtl/instr_sequencer.sv
// instr_sequencer
//   Multi-cycle instruction fetch / decode / execute / write-back sequencer.
//   An instruction is fetched from a word-addressed instruction memory using a
//   req/ack handshake. Two-word instructions (I_TYPE, M_TYPE) fetch an extra
//   immediate word. The decoded instruction is handed to an external execution
//   unit through exec_start/exec_done, and a register-file write strobe is
//   issued in write-back.
//
//   Opcode encoding (instr_out[2:0]):
//     0 R_TYPE, 1 I_TYPE, 2 B_TYPE, 3 J_TYPE, 4 M_TYPE, 7 SYS_END,
//     5 and 6 are unassigned and retire as NOPs.
//
// Ports
//   clock, reset_n            clock and asynchronous active-low reset
//   start                     pulse that leaves IDLE
//   mem_req/mem_addr          instruction-memory read request and word address
//   mem_rdata/mem_ack         read data and request completion
//   instr_out/imm_out         latched instruction word and immediate word
//   instr_valid               high for the single DECODE cycle
//   rf_write_req              decoder write flag, sampled in DECODE
//   exec_start/exec_done      execution handshake
//   branch_taken/target       redirect, sampled with exec_done
//   rf_we                     register-file write strobe (WB cycle)
//   pc, halted, retired       program counter, halt flag, retired count
module instr_sequencer #(
  parameter logic [15:0] RESET_PC = 16'h0000
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        start,
  output logic        mem_req,
  output logic [15:0] mem_addr,
  input  logic [15:0] mem_rdata,
  input  logic        mem_ack,
  output logic [15:0] instr_out,
  output logic [15:0] imm_out,
  output logic        instr_valid,
  input  logic        rf_write_req,
  output logic        exec_start,
  input  logic        exec_done,
  input  logic        branch_taken,
  input  logic [15:0] branch_target,
  output logic        rf_we,
  output logic [15:0] pc,
  output logic        halted,
  output logic [15:0] retired
);

  localparam logic [2:0] OP_R_TYPE  = 3'd0;
  localparam logic [2:0] OP_I_TYPE  = 3'd1;
  localparam logic [2:0] OP_B_TYPE  = 3'd2;
  localparam logic [2:0] OP_J_TYPE  = 3'd3;
  localparam logic [2:0] OP_M_TYPE  = 3'd4;
  localparam logic [2:0] OP_SYS_END = 3'd7;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    FETCH_IMM,
    DECODE,
    EXEC,
    WB,
    HALTED
  } state_t;

  state_t state, state_next;
  logic   rf_wr_latched;
  logic   exec_first;
  logic [2:0] opcode;

  function automatic logic is_two_word(input logic [2:0] op);
    return (op == OP_I_TYPE) || (op == OP_M_TYPE);
  endfunction

  function automatic logic is_exec_op(input logic [2:0] op);
    return (op == OP_R_TYPE) || (op == OP_I_TYPE) || (op == OP_B_TYPE) ||
           (op == OP_J_TYPE) || (op == OP_M_TYPE);
  endfunction

  assign opcode = instr_out[2:0];

  // State register.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_next;
  end

  // Next-state and Moore outputs. mem_addr is only driven while a request is
  // outstanding so that it reads as zero in reset and in idle states.
  always_comb begin
    state_next  = state;
    mem_req     = 1'b0;
    instr_valid = 1'b0;
    exec_start  = 1'b0;
    rf_we       = 1'b0;
    halted      = 1'b0;
    case (state)
      IDLE: begin
        if (start) state_next = FETCH;
      end
      FETCH: begin
        mem_req = 1'b1;
        if (mem_ack) state_next = is_two_word(mem_rdata[2:0]) ? FETCH_IMM : DECODE;
      end
      FETCH_IMM: begin
        mem_req = 1'b1;
        if (mem_ack) state_next = DECODE;
      end
      DECODE: begin
        instr_valid = 1'b1;
        if (opcode == OP_SYS_END)  state_next = HALTED;
        else if (is_exec_op(opcode)) state_next = EXEC;
        else                       state_next = FETCH;
      end
      EXEC: begin
        exec_start = exec_first;
        if (exec_done) state_next = WB;
      end
      WB: begin
        rf_we      = rf_wr_latched;
        state_next = FETCH;
      end
      HALTED: begin
        halted = 1'b1;
      end
      default: state_next = IDLE;
    endcase
  end

  assign mem_addr = mem_req ? pc : 16'h0000;

  // Datapath registers. NOPs and SYS_END retire as they leave DECODE; executed
  // instructions retire in WB. A taken branch overrides the already-advanced pc.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      pc            <= RESET_PC;
      instr_out     <= 16'h0000;
      imm_out       <= 16'h0000;
      rf_wr_latched <= 1'b0;
      exec_first    <= 1'b0;
      retired       <= 16'h0000;
    end else begin
      case (state)
        FETCH: begin
          if (mem_ack) begin
            instr_out <= mem_rdata;
            pc        <= pc + 16'd1;
            if (!is_two_word(mem_rdata[2:0])) imm_out <= 16'h0000;
          end
        end
        FETCH_IMM: begin
          if (mem_ack) begin
            imm_out <= mem_rdata;
            pc      <= pc + 16'd1;
          end
        end
        DECODE: begin
          rf_wr_latched <= rf_write_req;
          exec_first    <= 1'b1;
          if (!is_exec_op(opcode)) retired <= retired + 16'd1;
        end
        EXEC: begin
          exec_first <= 1'b0;
          if (exec_done && branch_taken) pc <= branch_target;
        end
        WB: begin
          retired <= retired + 16'd1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_instr_sequencer.sv
// tb_instr_sequencer
//   Self-checking bench for instr_sequencer: a table of single-instruction
//   scenarios with hand-derived results, hand-written halt and reset-mid-fetch
//   sequences, and a randomized instruction stream checked against an
//   instruction-level reference model.
module tb_instr_sequencer;

  logic        clock;
  logic        reset_n;
  logic        start;
  logic        mem_req;
  logic [15:0] mem_addr;
  logic [15:0] mem_rdata;
  logic        mem_ack;
  logic [15:0] instr_out;
  logic [15:0] imm_out;
  logic        instr_valid;
  logic        rf_write_req;
  logic        exec_start;
  logic        exec_done;
  logic        branch_taken;
  logic [15:0] branch_target;
  logic        rf_we;
  logic [15:0] pc;
  logic        halted;
  logic [15:0] retired;

  int vectors;
  int miscompares;
  logic [15:0] mem [0:65535];

  instr_sequencer #(.RESET_PC(16'h0000)) dut (
    .clock(clock), .reset_n(reset_n), .start(start),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .instr_out(instr_out), .imm_out(imm_out), .instr_valid(instr_valid),
    .rf_write_req(rf_write_req), .exec_start(exec_start), .exec_done(exec_done),
    .branch_taken(branch_taken), .branch_target(branch_target), .rf_we(rf_we),
    .pc(pc), .halted(halted), .retired(retired)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic        doReset;
    logic [15:0] at;
    logic [15:0] word;
    logic [15:0] imm;
    int          ackD;
    int          doneD;
    logic        br;
    logic [15:0] tgt;
    logic        rf;
    logic [15:0] expPc;
    logic [15:0] expImm;
    logic        expRfWe;
    int          expCycles;
    logic [15:0] expRetired;
  } vec_t;

  // Compare one observed value with its required value.
  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic clearInputs();
    start         = 1'b0;
    mem_ack       = 1'b0;
    mem_rdata     = 16'h0000;
    rf_write_req  = 1'b0;
    exec_done     = 1'b0;
    branch_taken  = 1'b0;
    branch_target = 16'h0000;
  endtask

  // Hold reset for two cycles, check the reset image, release.
  task automatic resetDut();
    clearInputs();
    reset_n = 1'b0;
    step();
    step();
    checkOutput("rst_pc", pc, 16'h0000);
    checkOutput("rst_mem_req", mem_req, 1'b0);
    checkOutput("rst_mem_addr", mem_addr, 16'h0000);
    checkOutput("rst_retired", retired, 16'h0000);
    checkOutput("rst_halted", halted, 1'b0);
    checkOutput("rst_instr_out", instr_out, 16'h0000);
    checkOutput("rst_imm_out", imm_out, 16'h0000);
    checkOutput("rst_strobes", {instr_valid, exec_start, rf_we}, 3'b000);
    reset_n = 1'b1;
    step();
  endtask

  task automatic startDut();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  // Run one instruction starting from a FETCH cycle, acting as memory and
  // execution unit with the given latencies, and check every phase.
  task automatic runInstr(input logic [15:0] at, input logic [15:0] word, input logic [15:0] immW,
                          input int ackD, input int doneD, input logic br, input logic [15:0] tgt,
                          input logic rf, input logic [15:0] expPc, input logic [15:0] expImm,
                          input logic expRfWe, input int expCycles, input logic [15:0] expRetired);
    logic [15:0] addr2;
    logic [15:0] fetchEnd;
    logic [2:0]  op;
    logic        two;
    logic        isExec;
    int phase, acked, waitCnt, doneCnt, cyc;
    logic first, fin;
    addr2 = at + 16'd1;
    op = word[2:0];
    two = (op == 3'd1) || (op == 3'd4);
    isExec = (op <= 3'd4);
    fetchEnd = at + (two ? 16'd2 : 16'd1);
    mem[at] = word;
    if (two) mem[addr2] = immW;
    phase = 0; acked = 0; waitCnt = 0; doneCnt = 0; cyc = 0;
    first = 1'b1; fin = 1'b0;
    while (!fin && cyc < 64) begin
      mem_ack       = 1'b0;
      exec_done     = 1'b0;
      mem_rdata     = 16'($urandom);
      rf_write_req  = 1'($urandom);
      start         = 1'($urandom);
      branch_taken  = 1'($urandom);
      branch_target = 16'($urandom);
      cyc++;
      case (phase)
        0: begin
          checkOutput("fetch_req", mem_req, 1'b1);
          checkOutput("fetch_addr", mem_addr, (acked == 0) ? at : addr2);
          if (waitCnt == ackD) begin
            mem_ack   = 1'b1;
            mem_rdata = mem[mem_addr];
            acked++;
            waitCnt = 0;
            if (acked == (two ? 2 : 1)) phase = 1;
          end else waitCnt++;
        end
        1: begin
          checkOutput("decode_valid", instr_valid, 1'b1);
          checkOutput("instr_out", instr_out, word);
          checkOutput("imm_out", imm_out, expImm);
          checkOutput("decode_pc", pc, fetchEnd);
          checkOutput("decode_retired", retired, expRetired - 16'd1);
          rf_write_req = rf;
          if (isExec) phase = 2;
          else fin = 1'b1;
        end
        2: begin
          checkOutput("exec_start", exec_start, first);
          first = 1'b0;
          if (doneCnt == doneD) begin
            exec_done     = 1'b1;
            branch_taken  = br;
            branch_target = tgt;
            phase = 3;
          end else begin
            exec_done    = 1'b0;
            doneCnt++;
          end
        end
        default: begin
          checkOutput("wb_rf_we", rf_we, expRfWe);
          fin = 1'b1;
        end
      endcase
      step();
    end
    clearInputs();
    if (!fin) begin
      vectors++;
      miscompares++;
      $display("[TB] FAIL timeout: instruction at %0h still in phase %0d after %0d cycles", at, phase, cyc);
    end
    checkOutput("cycles", cyc, expCycles);
    checkOutput("retired", retired, expRetired);
    checkOutput("pc_after", pc, expPc);
    if (op == 3'd7) begin
      checkOutput("halted", halted, 1'b1);
      checkOutput("halt_mem_req", mem_req, 1'b0);
    end else begin
      checkOutput("next_req", mem_req, 1'b1);
      checkOutput("next_addr", mem_addr, expPc);
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    if (v.doReset) begin
      resetDut();
      startDut();
    end
    runInstr(v.at, v.word, v.imm, v.ackD, v.doneD, v.br, v.tgt, v.rf,
             v.expPc, v.expImm, v.expRfWe, v.expCycles, v.expRetired);
  endtask

  initial begin
    vec_t vecs[8];
    logic [15:0] curPc, curRet, w, immW, tgt, expPc;
    logic [2:0] op;
    logic br, rf, two, isExec;
    int ackD, doneD, words, cycles;

    vectors = 0;
    miscompares = 0;
    reset_n = 1'b0;
    clearInputs();

    // doReset at word imm ackD doneD br tgt rf | expPc expImm expRfWe expCycles expRetired
    vecs[0] = '{1'b1, 16'h0000, 16'h1230, 16'h0000, 0, 0, 1'b0, 16'h0000, 1'b1, 16'h0001, 16'h0000, 1'b1, 4,  16'd1};
    vecs[1] = '{1'b1, 16'h0000, 16'h0011, 16'hBEEF, 3, 0, 1'b0, 16'h0000, 1'b1, 16'h0002, 16'hBEEF, 1'b1, 11, 16'd1};
    vecs[2] = '{1'b0, 16'h0002, 16'h0003, 16'h0000, 0, 1, 1'b1, 16'h0005, 1'b0, 16'h0005, 16'h0000, 1'b0, 5,  16'd2};
    vecs[3] = '{1'b0, 16'h0005, 16'hA002, 16'h0000, 1, 0, 1'b1, 16'h0040, 1'b0, 16'h0040, 16'h0000, 1'b0, 5,  16'd3};
    vecs[4] = '{1'b0, 16'h0040, 16'h0003, 16'h0000, 0, 0, 1'b1, 16'hFFFF, 1'b1, 16'hFFFF, 16'h0000, 1'b1, 4,  16'd4};
    vecs[5] = '{1'b0, 16'hFFFF, 16'h7774, 16'h1234, 0, 0, 1'b0, 16'h0000, 1'b1, 16'h0001, 16'h1234, 1'b1, 5,  16'd5};
    vecs[6] = '{1'b0, 16'h0001, 16'h0005, 16'h0000, 0, 0, 1'b0, 16'h0000, 1'b1, 16'h0002, 16'h0000, 1'b0, 2,  16'd6};
    vecs[7] = '{1'b0, 16'h0002, 16'h5550, 16'h0000, 2, 2, 1'b1, 16'h0010, 1'b0, 16'h0010, 16'h0000, 1'b0, 8,  16'd7};

    for (int i = 0; i < 8; i++) applyStimulus(vecs[i]);

    // SYS_END halts for good: start pulses and stray acks change nothing.
    runInstr(16'h0010, 16'h0007, 16'h0000, 0, 0, 1'b0, 16'h0000, 1'b0,
             16'h0011, 16'h0000, 1'b0, 2, 16'd8);
    for (int i = 0; i < 20; i++) begin
      start   = (i % 2 == 0);
      mem_ack = 1'($urandom);
      step();
      checkOutput("halt_hold", halted, 1'b1);
      checkOutput("halt_no_req", mem_req, 1'b0);
      checkOutput("halt_retired", retired, 16'd8);
    end
    clearInputs();

    // Reset in the middle of a fetch wait: request drops at once, late ack ignored.
    resetDut();
    startDut();
    runInstr(16'h0000, 16'h0020, 16'h0000, 0, 0, 1'b0, 16'h0000, 1'b0,
             16'h0001, 16'h0000, 1'b0, 4, 16'd1);
    step();
    step();
    checkOutput("wait_req", mem_req, 1'b1);
    #2 reset_n = 1'b0;
    #1;
    checkOutput("async_req_drop", mem_req, 1'b0);
    checkOutput("async_pc", pc, 16'h0000);
    checkOutput("async_retired", retired, 16'h0000);
    step();
    reset_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      mem_ack   = 1'b1;
      mem_rdata = 16'h0001;
      step();
      checkOutput("late_ack_req", mem_req, 1'b0);
      checkOutput("late_ack_pc", pc, 16'h0000);
      checkOutput("late_ack_valid", instr_valid, 1'b0);
    end
    clearInputs();
    startDut();
    runInstr(16'h0000, 16'h0E10, 16'h0000, 1, 0, 1'b0, 16'h0000, 1'b1,
             16'h0001, 16'h0000, 1'b1, 5, 16'd1);

    // Randomized instruction stream against an instruction-level model.
    resetDut();
    startDut();
    curPc = 16'h0000;
    curRet = 16'h0000;
    for (int i = 0; i < 150; i++) begin
      op     = 3'($urandom_range(0, 6));
      w      = 16'($urandom);
      w[2:0] = op;
      immW   = 16'($urandom);
      ackD   = $urandom_range(0, 3);
      doneD  = $urandom_range(0, 2);
      br     = 1'($urandom);
      tgt    = 16'($urandom);
      rf     = 1'($urandom);
      two    = (op == 3'd1) || (op == 3'd4);
      isExec = (op <= 3'd4);
      words  = two ? 2 : 1;
      expPc  = (isExec && br) ? tgt : curPc + 16'(words);
      cycles = words * (ackD + 1) + 1 + (isExec ? doneD + 2 : 0);
      curRet = curRet + 16'd1;
      runInstr(curPc, w, immW, ackD, doneD, br, tgt, rf, expPc,
               two ? immW : 16'h0000, isExec && rf, cycles, curRet);
      curPc = expPc;
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/instr_sequencer.md
INSTR_SEQUENCER -- requirements
Module: instr_sequencer

Interface
REQ-001 The block SHALL have parameter RESET_PC, default 16'h0000, the word address of the first fetch after reset.
REQ-002 The block SHALL use one clock; reset is asynchronous and active-low.
REQ-003 clock  input  1  rising-edge clock for all state.
REQ-004 reset_n  input  1  asynchronous active-low reset.
REQ-005 start  input  1  single-cycle pulse that leaves IDLE.
REQ-006 mem_req  output  1  instruction-memory read request.
REQ-007 mem_addr  output  16  word address of the request.
REQ-008 mem_rdata  input  16  read data, valid with mem_ack.
REQ-009 mem_ack  input  1  completes the outstanding request.
REQ-010 instr_out  output  16  latched instruction word; instr_out[2:0] is the opcode.
REQ-011 imm_out  output  16  latched second word for I_TYPE/M_TYPE; otherwise 16'h0000.
REQ-012 instr_valid  output  1  high for the single DECODE cycle.
REQ-013 rf_write_req  input  1  decoder rfWrite flag, sampled in DECODE.
REQ-014 exec_start  output  1  single-cycle pulse on entry to EXEC.
REQ-015 exec_done  input  1  execution complete.
REQ-016 branch_taken  input  1  redirect request, sampled with exec_done.
REQ-017 branch_target  input  16  redirect address, sampled with exec_done.
REQ-018 rf_we  output  1  register-file write strobe, high for the single WB cycle.
REQ-019 pc  output  16  current program counter.
REQ-020 halted  output  1  high while in HALTED.
REQ-021 retired  output  16  count of completed instructions.

Function
REQ-022 States SHALL be IDLE, FETCH, FETCH_IMM, DECODE, EXEC, WB and HALTED.
REQ-023 IDLE: on start=1, next state SHALL be FETCH; otherwise the block stays in IDLE.
REQ-024 FETCH/FETCH_IMM: mem_req=1 and mem_addr=pc SHALL be held stable until the cycle mem_ack=1.
REQ-025 On ack in FETCH: instr_out<=mem_rdata and pc<=pc+1 (16-bit wrap, FFFF->0000). Next state SHALL be FETCH_IMM if the opcode is I_TYPE or M_TYPE; otherwise DECODE, with imm_out<=0.
REQ-026 On ack in FETCH_IMM: imm_out<=mem_rdata and pc<=pc+1 (wrapping). Next state SHALL be DECODE.
REQ-027 mem_ack SHALL be ignored when mem_req=0.
REQ-028 DECODE lasts one cycle with instr_valid=1; rf_write_req SHALL be latched in this cycle.
REQ-029 DECODE transitions: SYS_END -> HALTED; R/I/B/J/M_TYPE -> EXEC; any other opcode SHALL be a NOP -> FETCH, with retired incremented and no exec_start or rf_we.
REQ-030 EXEC: exec_start=1 in the first EXEC cycle only; exec_done SHALL be honoured from that first cycle onward, including the same cycle as exec_start.
REQ-031 On exec_done: if branch_taken=1 then pc<=branch_target, overriding the fetch increment; next state SHALL be WB.
REQ-032 WB lasts one cycle: rf_we = latched rf_write_req, retired<=retired+1 (wraps), next state SHALL be FETCH.
REQ-033 HALTED SHALL be absorbing: halted=1, start ignored, no memory requests, retired incremented once on entry.
REQ-034 Minimum latency for a single-word instruction with same-cycle ack and done SHALL be 4 cycles (FETCH, DECODE, EXEC, WB); a double-word instruction SHALL take 5.
REQ-035 start asserted outside IDLE SHALL be ignored.

Reset
REQ-036 On reset_n=0, immediately and independent of clock: state=IDLE, pc=RESET_PC, and every other output = 0.
REQ-037 Reset mid-fetch SHALL drop mem_req that same instant; a late mem_ack after release SHALL be ignored.

Verification
REQ-038 R_TYPE word at 0, ack same cycle, exec_done on exec_start, rf_write_req=1 -> FETCH→DECODE→EXEC→WB in 4 cycles, rf_we one pulse, pc=1, retired=1.
REQ-039 I_TYPE at 0, immediate 16'hBEEF at 1, ack delayed 3 cycles per word -> mem_addr held stable through each wait, imm_out=BEEF, pc=2.
REQ-040 B_TYPE at 5 with exec_done, branch_taken=1, branch_target=16'h0040 -> next mem_addr=0x0040, rf_we=0.
REQ-041 pc=16'hFFFF holding an M_TYPE -> immediate fetched from 0x0000, pc=0x0001.
REQ-042 SYS_END -> halted=1 and mem_req=0 permanently while start pulses; retired incremented once.
REQ-043 reset_n low during a FETCH wait, then released -> IDLE, pc=RESET_PC, no mem_req until start.
